// File: rtl/csr_initiator_pkg.sv
// Shared types for the AXI-lite CSR initiator: FSM state, command/response records
// and AXI response codes.
package csr_initiator_pkg;

  localparam int unsigned CSR_ADDR_W = 8;
  localparam int unsigned CSR_DATA_W = 64;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StRsp
  } t_csr_init_state;

  typedef struct packed {
    logic                  write;
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_DATA_W-1:0] data;
  } t_csr_cmd;

  typedef struct packed {
    logic [CSR_DATA_W-1:0] data;
    logic                  error;
    logic                  timeout;
  } t_csr_rsp;

endpackage

// File: rtl/csr_initiator.sv
// AXI-lite initiator issuing single 64-bit CSR reads/writes, one at a time.
// Optional watchdog enabled by defining CSR_INITIATOR_TIMEOUT_EN.
module csr_initiator
  import csr_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W         = CSR_ADDR_W,
  parameter int unsigned DATA_W         = CSR_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_error_o,
  output logic              rsp_timeout_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic              bvalid_i,
  output logic              bready_o,
  input  logic [1:0]        bresp_i,
  output logic              arvalid_o,
  input  logic              arready_i,
  output logic [ADDR_W-1:0] araddr_o,
  input  logic              rvalid_i,
  output logic              rready_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i
);

  t_csr_init_state   state_q;
  logic              aw_done_q, w_done_q;
  logic              awvalid_q, wvalid_q, arvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  t_csr_rsp          rsp_q;
  logic              rsp_valid_q;

  logic aw_hs, w_hs, ar_hs, cmd_hs;
  logic progress, tmo_hit, tmo_fire;

  assign aw_hs  = awvalid_q & awready_i;
  assign w_hs   = wvalid_q & wready_i;
  assign ar_hs  = arvalid_q & arready_i;
  assign cmd_hs = cmd_valid_i & cmd_ready_o;

  // Any handshake in the current state beats a simultaneous watchdog expiry.
  always_comb begin
    progress = 1'b0;
    unique case (state_q)
      StWrReq:  progress = aw_hs | w_hs;
      StWrResp: progress = bvalid_i;
      StRdReq:  progress = ar_hs;
      StRdResp: progress = rvalid_i;
      default:  progress = 1'b0;
    endcase
  end

  assign tmo_fire = tmo_hit & ~progress;

`ifdef CSR_INITIATOR_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TmoW-1:0] tmo_cnt_q;
  logic            busy;

  assign busy    = state_q inside {StWrReq, StWrResp, StRdReq, StRdResp};
  assign tmo_hit = busy & (tmo_cnt_q >= TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || cmd_hs) begin
      tmo_cnt_q <= '0;
    end else if (busy && (tmo_cnt_q < TmoW'(TIMEOUT_CYCLES))) begin
      tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
    end
  end

  assign rsp_timeout_o = rsp_q.timeout;
`else
  logic unused_tmo;

  assign tmo_hit       = 1'b0;
  assign rsp_timeout_o = 1'b0;
  assign unused_tmo    = ^{TIMEOUT_CYCLES, rsp_q.timeout};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else if (tmo_fire) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_q       <= '{data: '1, error: 1'b1, timeout: 1'b1};
      rsp_valid_q <= 1'b1;
      state_q     <= StRsp;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid_i) begin
            addr_q    <= {cmd_addr_i[ADDR_W-1:3], 3'b000};
            wdata_q   <= cmd_data_i;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (cmd_write_i) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrReq;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdReq;
            end
          end
        end
        StWrReq: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
            state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (bvalid_i) begin
            rsp_q       <= '{data: '0, error: (bresp_i != AXI_RESP_OKAY), timeout: 1'b0};
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRdReq: begin
          if (ar_hs) begin
            arvalid_q <= 1'b0;
            state_q   <= StRdResp;
          end
        end
        StRdResp: begin
          if (rvalid_i) begin
            rsp_q       <= '{data: rdata_i, error: (rresp_i != AXI_RESP_OKAY), timeout: 1'b0};
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StRsp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr_i[2:0];

  assign cmd_ready_o = (state_q == StIdle);
  // Late B/R beats are drained in every state except while a response is pending.
  assign bready_o    = (state_q != StRsp);
  assign rready_o    = (state_q != StRsp);
  assign awvalid_o   = awvalid_q;
  assign wvalid_o    = wvalid_q;
  assign arvalid_o   = arvalid_q;
  assign awaddr_o    = addr_q;
  assign araddr_o    = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = '1;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_q.data;
  assign rsp_error_o = rsp_q.error;

endmodule

// File: tb/tb_csr_initiator.sv
// Directed bench for csr_initiator: AXI-lite responder model plus response scoreboard.
module tb_csr_initiator;
  import csr_initiator_pkg::*;

`ifdef CSR_INITIATOR_TIMEOUT_EN
  localparam int unsigned Tmo = 16;
`else
  localparam int unsigned Tmo = 1024;
`endif

  logic        clk, reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [63:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [63:0] rsp_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [7:0]  awaddr, araddr, wstrb;
  logic [63:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  csr_initiator #(.ADDR_W(8), .DATA_W(64), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout),
    .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr),
    .wvalid_o(wvalid), .wready_i(wready), .wdata_o(wdata), .wstrb_o(wstrb),
    .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp),
    .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr),
    .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rresp_i(rresp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Responder model: configurable ready delays, zero-latency B/R, small CSR memory.
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  bit          ar_never = 0, b_hold = 0, inject_r = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [63:0] mem [32];
  int          aw_cnt = 0, w_cnt = 0;
  bit          aw_got, w_got, ar_got, b_fire, r_fire, rst_seen;
  int          aw_wait, w_wait, ar_wait;
  logic [7:0]  wr_addr, rd_addr, wr_strb;
  logic [63:0] wr_data;

  initial begin
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
    wr_addr = 0; rd_addr = 0; wr_strb = 0; wr_data = 0;
    for (int i = 0; i < 32; i++) mem[i] = 64'h0;
    mem[0] = 64'h1000_0100_0000_0000;
    forever begin
      @(negedge clk);
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
      rst_seen = reset;
      if (reset) begin
        aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
      end else begin
        if (awvalid && awready) begin
          aw_got = 1; wr_addr = awaddr; aw_cnt++; aw_wait = 0;
        end else if (awvalid) aw_wait++;
        if (wvalid && wready) begin
          w_got = 1; wr_data = wdata; wr_strb = wstrb; w_cnt++; w_wait = 0;
        end else if (wvalid) w_wait++;
        if (arvalid && arready) begin
          ar_got = 1; rd_addr = araddr; ar_wait = 0;
        end else if (arvalid) ar_wait++;
      end
      @(posedge clk);
      #1;
      if (b_fire || rst_seen) bvalid = 0;
      if (r_fire || rst_seen) rvalid = 0;
      if (aw_got && w_got && !b_hold && !bvalid) begin
        mem[wr_addr[7:3]] = wr_data;
        bvalid = 1; bresp = cfg_bresp; aw_got = 0; w_got = 0;
      end
      if (ar_got && !rvalid) begin
        rvalid = 1; rdata = mem[rd_addr[7:3]]; rresp = cfg_rresp; ar_got = 0;
      end
      if (inject_r) begin
        rvalid = 1; rdata = 64'hBAD0_BAD0_BAD0_BAD0; rresp = 2'b00; inject_r = 0;
      end
      awready = awvalid && (aw_wait >= aw_dly);
      wready  = wvalid && (w_wait >= w_dly);
      arready = arvalid && !ar_never && (ar_wait >= ar_dly);
    end
  end

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        tmo;
  } exp_t;
  exp_t sb[$];
  int   acc_cyc;

  task automatic push_exp(input logic [63:0] d, input logic e, input logic t);
    exp_t x;
    x.data = d; x.err = e; x.tmo = t;
    sb.push_back(x);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic send(input bit wr, input logic [7:0] a, input logic [63:0] d);
    int k;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_data = d;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 20) check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int lat, input int hold);
    int          k;
    exp_t        x;
    logic [63:0] d0;
    logic        e0, t0;
    bit          stable;
    for (k = 0; k < 200; k++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    if (k == 200) begin
      check("rsp_wait_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    if (lat >= 0) check("rsp_latency", 64'(cyc - acc_cyc), 64'(lat));
    check("valids_low_in_rsp", {61'd0, awvalid, wvalid, arvalid}, 64'd0);
    if (sb.size() == 0) begin
      check("unexpected_rsp", 64'(rsp_valid), 64'd0);
    end else begin
      x = sb.pop_front();
      check("rsp_data", rsp_data, x.data);
      check("rsp_error", 64'(rsp_error), 64'(x.err));
      check("rsp_timeout", 64'(rsp_timeout), 64'(x.tmo));
    end
    if (hold > 0) begin
      d0 = rsp_data; e0 = rsp_error; t0 = rsp_timeout; stable = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        stable &= rsp_valid && !cmd_ready && (rsp_data === d0) && (rsp_error === e0)
                  && (rsp_timeout === t0);
      end
      check("rsp_hold_stable", 64'(stable), 64'd1);
      @(posedge clk);
      #1;
      rsp_ready = 1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit held;
    int aw0, w0;
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {57'd0, awvalid, wvalid, arvalid, rsp_valid, rsp_error,
                            rsp_timeout, cmd_ready}, 64'd1);
    check("reset_rsp_data", rsp_data, 64'd0);
    @(posedge clk);
    #1;
    reset = 0;

    // Zero-wait write, then read back (also via an unaligned address).
    push_exp(64'd0, 1'b0, 1'b0);
    send(1'b1, 8'h28, 64'h0000_0000_1234_5678);
    wait_rsp(3, 0);
    check("wr_addr_on_bus", 64'(wr_addr), 64'h28);
    check("wr_data_on_bus", wr_data, 64'h0000_0000_1234_5678);
    check("wr_strb_on_bus", 64'(wr_strb), 64'hFF);
    push_exp(64'h0000_0000_1234_5678, 1'b0, 1'b0);
    send(1'b0, 8'h28, 64'd0);
    wait_rsp(3, 0);
    push_exp(64'h0000_0000_1234_5678, 1'b0, 1'b0);
    send(1'b0, 8'h2D, 64'd0);
    wait_rsp(3, 0);
    check("rd_addr_aligned", 64'(rd_addr), 64'h28);

    push_exp(64'h1000_0100_0000_0000, 1'b0, 1'b0);
    send(1'b0, 8'h00, 64'd0);
    wait_rsp(3, 0);

    // AW accepted three cycles before W.
    w_dly = 3; aw0 = aw_cnt; w0 = w_cnt; held = 1;
    push_exp(64'd0, 1'b0, 1'b0);
    send(1'b1, 8'h08, 64'hDEAD_BEEF_CAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      held &= wvalid;
    end
    check("wvalid_held", 64'(held), 64'd1);
    wait_rsp(6, 0);
    w_dly = 0;
    check("aw_issued_once", 64'(aw_cnt - aw0), 64'd1);
    check("w_issued_once", 64'(w_cnt - w0), 64'd1);
    repeat (3) @(negedge clk);
    check("no_extra_rsp", 64'(rsp_valid), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;

    // SLVERR read with the consumer stalling for five cycles.
    cfg_rresp = 2'b10; rsp_ready = 0;
    push_exp(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0);
    send(1'b0, 8'h08, 64'd0);
    wait_rsp(3, 5);
    cfg_rresp = 2'b00;

    cfg_bresp = 2'b11;
    push_exp(64'd0, 1'b1, 1'b0);
    send(1'b1, 8'h30, 64'h55);
    wait_rsp(3, 0);
    cfg_bresp = 2'b00;

    // Reset while waiting for B: command is dropped without a response.
    b_hold = 1;
    send(1'b1, 8'h10, 64'h1111_2222_3333_4444);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0; b_hold = 0;
    @(negedge clk);
    check("midreset_state", {59'd0, awvalid, wvalid, arvalid, rsp_valid, cmd_ready}, 64'd1);
    repeat (3) @(negedge clk);
    check("midreset_no_rsp", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    push_exp(64'd0, 1'b0, 1'b0);
    send(1'b0, 8'h10, 64'd0);
    wait_rsp(3, 0);
    push_exp(64'd0, 1'b0, 1'b0);
    send(1'b1, 8'h10, 64'hA5A5_0000_FFFF_0001);
    wait_rsp(3, 0);
    push_exp(64'hA5A5_0000_FFFF_0001, 1'b0, 1'b0);
    send(1'b0, 8'h10, 64'd0);
    wait_rsp(3, 0);

`ifdef CSR_INITIATOR_TIMEOUT_EN
    // Hung AR channel: watchdog aborts after 16 busy cycles, then a late R beat is drained.
    ar_never = 1;
    push_exp(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    send(1'b0, 8'h18, 64'd0);
    wait_rsp(17, 0);
    ar_never = 0;
    @(negedge clk);
    inject_r = 1;
    repeat (2) @(negedge clk);
    check("late_r_drained", {62'd0, rvalid, rsp_valid}, 64'd0);
    @(posedge clk);
    #1;
    push_exp(64'h1000_0100_0000_0000, 1'b0, 1'b0);
    send(1'b0, 8'h00, 64'd0);
    wait_rsp(3, 0);
`endif

    check("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
